// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment patterns,
// scan FSM state encoding and a width helper.
package sevseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    // Glyph lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        pattern_o = SEG_OFF[6:0];
        case (nibble_i)
            4'h0:    pattern_o = SEG_0;
            4'h1:    pattern_o = SEG_1;
            4'h2:    pattern_o = SEG_2;
            4'h3:    pattern_o = SEG_3;
            4'h4:    pattern_o = SEG_4;
            4'h5:    pattern_o = SEG_5;
            4'h6:    pattern_o = SEG_6;
            4'h7:    pattern_o = SEG_7;
            4'h8:    pattern_o = SEG_8;
            4'h9:    pattern_o = SEG_9;
            4'hA:    pattern_o = SEG_A;
            4'hB:    pattern_o = SEG_B;
            4'hC:    pattern_o = SEG_C;
            4'hD:    pattern_o = SEG_D;
            4'hE:    pattern_o = SEG_E;
            4'hF:    pattern_o = SEG_F;
            default: pattern_o = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment scanner with per-frame input snapshot.
// Define SEVSEG_BLINK_EN to add the blinkMask input and frame-based blink phase.
module seven_segment_scanner
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYC    = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lzs,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blinkMask,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frameStart
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLANK_CYC < 0 ||
        BLANK_CYC >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_param_check
        $error("seven_segment_scanner: illegal parameter combination");
    end

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic                    first_q;
    logic                    snap_take_s;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic                    snap_lzs_q, snap_lzs_d;
    logic [NUM_DIGITS-1:0]   blink_dark_s;
    logic [NUM_DIGITS-1:0]   dark_s;
    logic [3:0]              nibble_s;
    logic [6:0]              pattern_s;
    logic                    dp_sel_s;
    logic                    dark_sel_s;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    // Prescaler/index advance, frame snapshot capture and slot state.
    always_comb begin
        pre_d         = pre_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        snap_lzs_d    = snap_lzs_q;
        if (pre_q == PRE_LAST) begin
            pre_d = {PRE_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
        // The very first edge after reset already sits at (0,0) without entering it.
        snap_take_s = first_q || ((pre_d == {PRE_W{1'b0}}) && (idx_d == {IDX_W{1'b0}}));
        if (snap_take_s) begin
            snap_digits_d = digits;
            snap_dp_d     = dp;
            snap_blank_d  = blank;
            snap_lzs_d    = lzs;
        end else begin
            snap_lzs_d    = snap_lzs_q;
        end
        if (int'(pre_d) < BLANK_CYC) begin
            state_d = ST_BLANK;
        end else begin
            state_d = ST_SHOW;
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int FR_W = clog2(BLINK_FRAMES);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic [NUM_DIGITS-1:0] snap_mask_q, snap_mask_d;

    // Blink phase steps once per frame snapshot, not counting the first frame after reset.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        snap_mask_d = snap_mask_q;
        if (snap_take_s) begin
            snap_mask_d = blinkMask;
            if (first_q) begin
                frame_cnt_d = {FR_W{1'b0}};
            end else if (frame_cnt_q == FR_LAST) begin
                frame_cnt_d = {FR_W{1'b0}};
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else begin
            blink_on_d = blink_on_q;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= {FR_W{1'b0}};
            blink_on_q  <= 1'b1;
            snap_mask_q <= {NUM_DIGITS{1'b0}};
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            snap_mask_q <= snap_mask_d;
        end
    end

    assign blink_dark_s = blink_on_d ? {NUM_DIGITS{1'b0}} : snap_mask_d;
`else
    assign blink_dark_s = {NUM_DIGITS{1'b0}};
`endif

    // Per-digit darkness, digit selection for the upcoming slot cycle.
    always_comb begin : p_dark
        logic run_zero;
        run_zero   = 1'b1;
        dark_s     = {NUM_DIGITS{1'b0}};
        nibble_s   = 4'h0;
        dp_sel_s   = 1'b0;
        dark_sel_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero  = run_zero && (snap_digits_d[4*i +: 4] == 4'h0);
            dark_s[i] = snap_blank_d[i] || blink_dark_s[i] ||
                        (snap_lzs_d && (i != 0) && run_zero);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble_s   = snap_digits_d[4*i +: 4];
                dp_sel_s   = snap_dp_d[i];
                dark_sel_s = dark_s[i];
            end else begin
                dp_sel_s   = dp_sel_s;
            end
        end
    end

    seg_hex_decoder u_decoder (
        .nibble_i  (nibble_s),
        .pattern_o (pattern_s)
    );

    // Output drive for the slot cycle being entered.
    always_comb begin
        seg_d         = SEG_OFF;
        an_d          = {NUM_DIGITS{1'b1}};
        frame_start_d = snap_take_s;
        case (state_d)
            ST_SHOW: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    an_d[i] = (idx_d != IDX_W'(i));
                end
                if (dark_sel_s) begin
                    seg_d = SEG_OFF;
                end else begin
                    seg_d = {!dp_sel_s, pattern_s};
                end
            end
            ST_BLANK: begin
                seg_d = SEG_OFF;
                an_d  = {NUM_DIGITS{1'b1}};
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = {NUM_DIGITS{1'b1}};
            end
        endcase
    end

    // Scan, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= {PRE_W{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            state_q       <= ST_BLANK;
            first_q       <= 1'b1;
            snap_digits_q <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_q     <= {NUM_DIGITS{1'b0}};
            snap_blank_q  <= {NUM_DIGITS{1'b0}};
            snap_lzs_q    <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= {NUM_DIGITS{1'b1}};
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            first_q       <= 1'b0;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_lzs_q    <= snap_lzs_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frameStart = frame_start_q;

endmodule
